// File: rtl/turn_signal_ctrl.sv
// Control stage for the taillight blink sequencers: switch synchronisers and
// debouncers, turn/hazard mode FSM, and the step-rate divider.
module turn_signal_ctrl #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int STEP_HZ         = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       in_clock,
  input  logic       reset,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_hazard,
  input  logic       sw_brake,
  output logic       left_step,
  output logic       left_clear_n,
  output logic       right_step,
  output logic       right_clear_n,
  output logic       brake_on,
  output logic [1:0] mode
);

  localparam int DIV   = CLK_HZ / STEP_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int SW_LEFT   = 0;
  localparam int SW_RIGHT  = 1;
  localparam int SW_HAZARD = 2;
  localparam int SW_BRAKE  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  logic [3:0] raw;
  logic [3:0] synced;
  logic [3:0] deb;

  assign raw = {sw_brake, sw_hazard, sw_right, sw_left};

  for (genvar i = 0; i < 4; i++) begin : g_switch
    logic [SYNC_STAGES-1:0] chain;
    logic [DB_W-1:0]        cnt;
    logic                   level;

    always_ff @(posedge in_clock or posedge reset) begin
      if (reset) begin
        chain <= '0;
      end else begin
        chain <= {chain[SYNC_STAGES-2:0], raw[i]};
      end
    end

    assign synced[i] = chain[SYNC_STAGES-1];

    // A disagreement accepted on the cycle the run length would reach
    // DEBOUNCE_CYCLES; any agreeing cycle restarts the run.
    always_ff @(posedge in_clock or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (synced[i] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= synced[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign deb[i] = level;
  end

  mode_t            state;
  mode_t            state_next;
  mode_t            target;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             left_active;
  logic             right_active;
  logic             left_step_next;
  logic             right_step_next;
  logic             left_clear_next;
  logic             right_clear_next;

  always_comb begin
    target = IDLE;
    if (deb[SW_HAZARD] || (deb[SW_LEFT] && deb[SW_RIGHT])) begin
      target = HAZARD;
    end else if (deb[SW_LEFT]) begin
      target = LEFT;
    end else if (deb[SW_RIGHT]) begin
      target = RIGHT;
    end
  end

  assign left_active  = (state == LEFT)  || (state == HAZARD);
  assign right_active = (state == RIGHT) || (state == HAZARD);

  // A mode change spends one cycle with both sequencers cleared and the
  // divider restarted, so the new pattern always begins from a known phase.
  always_comb begin
    state_next       = state;
    div_next         = '0;
    left_step_next   = 1'b0;
    right_step_next  = 1'b0;
    left_clear_next  = 1'b0;
    right_clear_next = 1'b0;
    if (state != target) begin
      state_next = target;
    end else begin
      left_clear_next  = left_active;
      right_clear_next = right_active;
      if (state != IDLE) begin
        div_next        = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        left_step_next  = left_active  && (div_cnt == DIV_LAST);
        right_step_next = right_active && (div_cnt == DIV_LAST);
      end
    end
  end

  always_ff @(posedge in_clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      left_step     <= 1'b0;
      right_step    <= 1'b0;
      left_clear_n  <= 1'b0;
      right_clear_n <= 1'b0;
      brake_on      <= 1'b0;
    end else begin
      state         <= state_next;
      div_cnt       <= div_next;
      left_step     <= left_step_next;
      right_step    <= right_step_next;
      left_clear_n  <= left_clear_next;
      right_clear_n <= right_clear_next;
      brake_on      <= deb[SW_BRAKE];
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Bench for turn_signal_ctrl: table vectors, hand-written corner sequences and
// randomized switch activity, all checked each cycle against a reference model.
module tb_turn_signal_ctrl;

  localparam int CLK_HZ = 16;
  localparam int STEP_HZ = 4;
  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int SYNC = 2;
  localparam int DEB = 3;

  logic       in_clock = 1'b0;
  logic       reset = 1'b0;
  logic       sw_left = 1'b0;
  logic       sw_right = 1'b0;
  logic       sw_hazard = 1'b0;
  logic       sw_brake = 1'b0;
  logic       left_step;
  logic       left_clear_n;
  logic       right_step;
  logic       right_clear_n;
  logic       brake_on;
  logic [1:0] mode;

  turn_signal_ctrl #(
    .CLK_HZ(CLK_HZ),
    .STEP_HZ(STEP_HZ),
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .in_clock(in_clock),
    .reset(reset),
    .sw_left(sw_left),
    .sw_right(sw_right),
    .sw_hazard(sw_hazard),
    .sw_brake(sw_brake),
    .left_step(left_step),
    .left_clear_n(left_clear_n),
    .right_step(right_step),
    .right_clear_n(right_clear_n),
    .brake_on(brake_on),
    .mode(mode)
  );

  always #5 in_clock = ~in_clock;

  int checks = 0;
  int failures = 0;

  // Reference model: raw samples per edge since reset, bit order {brake,hazard,right,left}
  logic [3:0] rawq[$];
  logic [3:0] m_deb;
  logic [1:0] m_mode;
  int         m_phase;
  logic       m_lstep, m_rstep, m_lclr, m_rclr, m_brake;

  typedef struct {
    logic [3:0] sw;
    int         hold;
    logic [1:0] exp_mode;
    logic       exp_brake;
    logic       exp_lclr;
    logic       exp_rclr;
  } vec_t;

  vec_t vecs[7];

  task automatic model_reset();
    rawq.delete();
    m_deb = '0;
    m_mode = 2'd0;
    m_phase = 0;
    m_lstep = 0; m_rstep = 0; m_lclr = 0; m_rclr = 0; m_brake = 0;
  endtask

  function automatic logic synced_after(int s, int edge_no);
    int idx;
    idx = edge_no - SYNC;
    if (idx < 0 || idx >= rawq.size()) return 1'b0;
    return rawq[idx][s];
  endfunction

  task automatic model_edge();
    logic [3:0] old_deb;
    logic [1:0] tgt;
    logic       all_diff, lact, ract;
    int         n;
    old_deb = m_deb;
    rawq.push_back({sw_brake, sw_hazard, sw_right, sw_left});
    n = rawq.size();
    for (int s = 0; s < 4; s++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= DEB; k++)
        if (synced_after(s, n - k) == old_deb[s]) all_diff = 1'b0;
      if (all_diff) m_deb[s] = ~old_deb[s];
    end
    if (old_deb[2] || (old_deb[0] && old_deb[1])) tgt = 2'd3;
    else if (old_deb[0]) tgt = 2'd1;
    else if (old_deb[1]) tgt = 2'd2;
    else tgt = 2'd0;
    m_brake = old_deb[3];
    if (tgt != m_mode) begin
      m_mode = tgt; m_phase = 0;
      m_lclr = 0; m_rclr = 0; m_lstep = 0; m_rstep = 0;
    end else begin
      lact = (m_mode == 2'd1) || (m_mode == 2'd3);
      ract = (m_mode == 2'd2) || (m_mode == 2'd3);
      m_lclr = lact;
      m_rclr = ract;
      if (m_mode != 2'd0) m_phase++;
      m_lstep = lact && (m_phase > 0) && (m_phase % DIV == 0);
      m_rstep = ract && (m_phase > 0) && (m_phase % DIV == 0);
    end
  endtask

  task automatic check_val(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("mode", mode, m_mode);
    check_val("left_step", {1'b0, left_step}, {1'b0, m_lstep});
    check_val("right_step", {1'b0, right_step}, {1'b0, m_rstep});
    check_val("left_clear_n", {1'b0, left_clear_n}, {1'b0, m_lclr});
    check_val("right_clear_n", {1'b0, right_clear_n}, {1'b0, m_rclr});
    check_val("brake_on", {1'b0, brake_on}, {1'b0, m_brake});
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_mode"}, mode, 2'd0);
    check_val({tag, "_steps"}, {left_step, right_step}, 2'b00);
    check_val({tag, "_clears"}, {left_clear_n, right_clear_n}, 2'b00);
    check_val({tag, "_brake"}, {1'b0, brake_on}, 2'b00);
  endtask

  task automatic tick();
    @(posedge in_clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_switches(input logic [3:0] sw);
    {sw_brake, sw_hazard, sw_right, sw_left} = sw;
  endtask

  task automatic apply_vector(input vec_t v, input int idx);
    set_switches(v.sw);
    for (int c = 0; c < v.hold; c++) tick();
    check_val($sformatf("vec%0d_mode", idx), mode, v.exp_mode);
    check_val($sformatf("vec%0d_brake", idx), {1'b0, brake_on}, {1'b0, v.exp_brake});
    check_val($sformatf("vec%0d_lclr", idx), {1'b0, left_clear_n}, {1'b0, v.exp_lclr});
    check_val($sformatf("vec%0d_rclr", idx), {1'b0, right_clear_n}, {1'b0, v.exp_rclr});
  endtask

  // Ticks until left_step is seen; n = ticks taken, or -1 if the budget expires
  task automatic wait_left_step(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (left_step) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, n2, idle_cnt, clr_at, step_at, saw_right_step, max_mode, hz_at;

    vecs[0] = '{4'b0000, 10, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'b0001, 10, 2'd1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'b1001, 10, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{4'b0010, 10, 2'd2, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'b0011, 10, 2'd3, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{4'b1100, 10, 2'd3, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{4'b0000, 10, 2'd0, 1'b0, 1'b0, 1'b0};

    #1 reset = 1'b1;
    model_reset();
    #1 check_reset_values("reset");
    #10 reset = 1'b0;

    for (int i = 0; i < 7; i++) apply_vector(vecs[i], i);

    // Left mode: steps every DIV cycles, right side idle
    set_switches(4'b0001);
    for (int c = 0; c < 12; c++) tick();
    saw_right_step = 0;
    wait_left_step(8, n);
    check_val("left_first_step_found", {1'b0, n > 0}, 2'b01);
    n2 = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (right_step) saw_right_step = 1;
      if (left_step) begin n2 = i; break; end
    end
    check_val("left_step_period", 2'(n2), 2'(DIV));
    check_val("left_period_found", {1'b0, n2 == DIV}, 2'b01);
    check_val("right_quiet_in_left", 2'(saw_right_step), 2'd0);

    // Short right glitch while idle is rejected
    set_switches(4'b0000);
    for (int c = 0; c < 12; c++) tick();
    sw_right = 1'b1;
    tick(); tick();
    sw_right = 1'b0;
    max_mode = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (int'(mode) > max_mode) max_mode = int'(mode);
    end
    check_val("glitch_mode_idle", 2'(max_mode), 2'd0);

    // Hazard: both sides step in the same cycle
    set_switches(4'b0100);
    for (int c = 0; c < 12; c++) tick();
    wait_left_step(8, n);
    check_val("hazard_step_found", {1'b0, n > 0}, 2'b01);
    check_val("hazard_lockstep", {1'b0, right_step}, 2'b01);

    // LEFT -> IDLE -> RIGHT with first right step DIV cycles after the clear cycle
    set_switches(4'b0001);
    for (int c = 0; c < 12; c++) tick();
    sw_left = 1'b0;
    tick();
    sw_right = 1'b1;
    idle_cnt = 0; clr_at = -1; step_at = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mode == 2'd0) idle_cnt++;
      if (mode == 2'd2 && !right_clear_n && clr_at < 0) clr_at = i;
      if (clr_at >= 0 && right_step && step_at < 0) step_at = i;
    end
    check_val("left_right_idle_cycles", 2'(idle_cnt), 2'd1);
    check_val("right_clear_seen", {1'b0, clr_at >= 0}, 2'b01);
    check_val("right_first_step_delay", 2'(step_at - clr_at), 2'(DIV));
    check_val("right_first_step_exact", {1'b0, (step_at - clr_at) == DIV}, 2'b01);

    // Async reset between hazard steps, then full re-debounce into HAZARD
    set_switches(4'b0100);
    for (int c = 0; c < 12; c++) tick();
    wait_left_step(8, n);
    check_val("pre_reset_step_found", {1'b0, n > 0}, 2'b01);
    #2 reset = 1'b1;
    model_reset();
    #1 check_reset_values("async_reset");
    @(posedge in_clock);
    #1 check_reset_values("held_reset");
    #3 reset = 1'b0;
    hz_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mode == 2'd3) begin hz_at = i; break; end
    end
    check_val("hazard_reentry_found", {1'b0, hz_at > 0}, 2'b01);
    check_val("hazard_reentry_cycles", 3'(hz_at) == 3'd6 ? 2'd1 : 2'd0, 2'd1);

    // Randomized switch activity against the model
    for (int seg = 0; seg < 150; seg++) begin
      set_switches(4'($urandom_range(0, 15)));
      n = $urandom_range(1, 9);
      for (int c = 0; c < n; c++) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
